// File: rtl/kat_adc_gain_sched.sv
`default_nettype none
// ============================================================================
//  Module   : kat_adc_gain_sched
//  Purpose  : Round-robin scheduler that shares one IIC gain_load/gain_value
//             port between NUM_REQ requesters, with a hold-off per write.
//  Revision : 1.0
// ============================================================================
module kat_adc_gain_sched #(
  parameter int NUM_REQ        = 4,
  parameter int GAIN_W         = 14,
  parameter int HOLDOFF_CYCLES = 4096,
  parameter bit SKIP_DUP       = 1'b1
) (
  input  logic                         app_clk,
  input  logic                         app_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*GAIN_W-1:0]    req_gain,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         gain_load,
  output logic [GAIN_W-1:0]            gain_value,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [15:0]                  load_count,
  output logic [15:0]                  skip_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_INIT = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [GAIN_W-1:0]   w_req_gain  [NUM_REQ];
  logic [GAIN_W-1:0]   r_slot_gain [NUM_REQ];
  logic [NUM_REQ-1:0]  r_slot_full, w_slot_full_nxt, r_req_ready;
  logic [ID_W-1:0]     r_rr, w_win, w_idx, r_grant_id;
  logic                w_found, w_grant, w_skip;
  logic [GAIN_W-1:0]   w_win_gain, r_last_gain, r_gain_value;
  logic                r_last_valid, r_gain_load;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_load_count, r_skip_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_gain[gi] = req_gain[gi*GAIN_W +: GAIN_W];
    end
  endgenerate

  // First full slot after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr) + k) % NUM_REQ);
      if (!w_found && r_slot_full[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_gain = r_slot_gain[w_win];

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_skip      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          if (SKIP_DUP && r_last_valid && (w_win_gain == r_last_gain)) w_skip = 1'b1;
          else                                                          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD:  w_state_nxt = S_HOLD;
      S_HOLD:  if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant and accept never hit the same slot: accept needs it empty, grant needs it full.
  always_comb begin
    w_slot_full_nxt = r_slot_full;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_win == ID_W'(i)))      w_slot_full_nxt[i] = 1'b0;
      else if (req_valid[i] && r_req_ready[i]) w_slot_full_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      r_slot_full  <= '0;
      r_req_ready  <= '0;
      r_rr         <= ID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_last_gain  <= '0;
      r_last_valid <= 1'b0;
      r_gain_value <= '0;
      r_gain_load  <= 1'b0;
      r_cnt        <= '0;
      r_load_count <= '0;
      r_skip_count <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_slot_gain[i] <= '0;
    end else begin
      r_slot_full <= w_slot_full_nxt;
      r_req_ready <= ~w_slot_full_nxt;
      r_gain_load <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && r_req_ready[i]) r_slot_gain[i] <= w_req_gain[i];
      end
      if (w_grant) begin
        r_rr       <= w_win;
        r_grant_id <= w_win;
        if (w_skip) begin
          r_skip_count <= r_skip_count + 16'd1;
        end else begin
          r_gain_value <= w_win_gain;
          r_last_gain  <= w_win_gain;
          r_last_valid <= 1'b1;
        end
      end
      if (r_state == S_LOAD) begin
        r_gain_load  <= 1'b1;
        r_load_count <= r_load_count + 16'd1;
        r_cnt        <= C_HOLD_INIT;
      end else if ((r_state == S_HOLD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign gain_load  = r_gain_load;
  assign gain_value = r_gain_value;
  assign grant_id   = r_grant_id;
  assign load_count = r_load_count;
  assign skip_count = r_skip_count;
  assign busy       = (r_state != S_IDLE) || (|r_slot_full);

endmodule
`default_nettype wire

// File: tb/tb_kat_adc_gain_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kat_adc_gain_sched
//  Purpose  : Directed self-checking bench for kat_adc_gain_sched.
//  Revision : 1.0
// ============================================================================
module tb_kat_adc_gain_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid, req_valid_nd;
  logic [55:0] req_gain;

  logic [3:0]  req_ready, req_ready_nd;
  logic        gain_load, gain_load_nd;
  logic [13:0] gain_value, gain_value_nd;
  logic        busy, busy_nd;
  logic [1:0]  grant_id, grant_id_nd;
  logic [15:0] load_count, load_count_nd;
  logic [15:0] skip_count, skip_count_nd;

  int errors = 0;
  int checks = 0;

  kat_adc_gain_sched #(.NUM_REQ(4), .GAIN_W(14), .HOLDOFF_CYCLES(8), .SKIP_DUP(1'b1)) dut (
    .app_clk(clk), .app_rst_n(rst_n), .req_valid(req_valid), .req_gain(req_gain),
    .req_ready(req_ready), .gain_load(gain_load), .gain_value(gain_value), .busy(busy),
    .grant_id(grant_id), .load_count(load_count), .skip_count(skip_count));

  kat_adc_gain_sched #(.NUM_REQ(4), .GAIN_W(14), .HOLDOFF_CYCLES(8), .SKIP_DUP(1'b0)) dut_nd (
    .app_clk(clk), .app_rst_n(rst_n), .req_valid(req_valid_nd), .req_gain(req_gain),
    .req_ready(req_ready_nd), .gain_load(gain_load_nd), .gain_value(gain_value_nd), .busy(busy_nd),
    .grant_id(grant_id_nd), .load_count(load_count_nd), .skip_count(skip_count_nd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gain(input int i, input logic [13:0] g);
    req_gain[i*14 +: 14] = g;
  endtask

  task automatic do_reset();
    req_valid = '0; req_valid_nd = '0; req_gain = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0; req_valid_nd = '0; req_gain = '0;
    #1;
    checks++; if ({gain_load, gain_value, busy, grant_id, load_count, skip_count, req_ready} !== '0) begin
      errors++; $display("FAIL reset_outputs: got load=%0b val=%h busy=%0b id=%0d lc=%0d sc=%0d rdy=%b expected all 0",
        gain_load, gain_value, busy, grant_id, load_count, skip_count, req_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (req_ready !== 4'hF) begin
      errors++; $display("FAIL reset_ready: req_ready=%b expected 1111", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_gain(2, 14'h0123);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    checks++; if (req_ready[2] !== 1'b0 || busy !== 1'b1 || gain_load !== 1'b0) begin
      errors++; $display("FAIL t1_accept: rdy2=%0b busy=%0b load=%0b expected 0 1 0", req_ready[2], busy, gain_load); end
    tick();
    checks++; if (gain_load !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL t1_grant: load=%0b rdy2=%0b expected 0 1", gain_load, req_ready[2]); end
    tick();
    checks++; if (gain_load !== 1'b1 || gain_value !== 14'h0123 || grant_id !== 2'd2 || load_count !== 16'd1) begin
      errors++; $display("FAIL t1_pulse: load=%0b val=%h id=%0d lc=%0d expected 1 0123 2 1",
        gain_load, gain_value, grant_id, load_count); end
    tick();
    checks++; if (gain_load !== 1'b0) begin
      errors++; $display("FAIL t1_one_cycle: load=%0b expected 0", gain_load); end
  endtask

  task automatic test_round_robin();
    int pcyc[$];
    int pid[$];
    logic [13:0] pval[$];
    logic bsy[64];
    do_reset();
    for (int i = 0; i < 4; i++) set_gain(i, 14'h0A00 + 14'(i));
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      bsy[k] = busy;
      if (gain_load) begin pcyc.push_back(k); pid.push_back(int'(grant_id)); pval.push_back(gain_value); end
    end
    checks++; if (pcyc.size() != 4) begin
      errors++; $display("FAIL t2_pulse_count: got %0d expected 4", pcyc.size()); end
    else begin
      for (int n = 0; n < 4; n++) begin
        checks++; if (pcyc[n] != 2 + 10*n || pid[n] != n || pval[n] !== 14'h0A00 + 14'(n)) begin
          errors++; $display("FAIL t2_pulse%0d: cyc=%0d id=%0d val=%h expected %0d %0d %h",
            n, pcyc[n], pid[n], pval[n], 2 + 10*n, n, 14'h0A00 + 14'(n)); end
      end
    end
    checks++; if (bsy[39] !== 1'b1 || bsy[40] !== 1'b0) begin
      errors++; $display("FAIL t2_busy_end: busy@39=%0b busy@40=%0b expected 1 0", bsy[39], bsy[40]); end
    checks++; if (load_count !== 16'd4) begin
      errors++; $display("FAIL t2_load_count: got %0d expected 4", load_count); end
  endtask

  task automatic test_skip_dup();
    int np, npn;
    do_reset();
    set_gain(0, 14'h0200);
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0001; req_valid_nd = 4'b0001;
      tick();
      req_valid = '0; req_valid_nd = '0;
      np = 0; npn = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (k == 1 && r == 1) begin
          checks++; if (req_ready[0] !== 1'b1 || skip_count !== 16'd1) begin
            errors++; $display("FAIL t3_skip: rdy0=%0b skip=%0d expected 1 1", req_ready[0], skip_count); end
        end
        if (gain_load) np++;
        if (gain_load_nd) npn++;
      end
      checks++; if (np != 1 - r || npn != 1) begin
        errors++; $display("FAIL t3_pulses_round%0d: dup_on=%0d dup_off=%0d expected %0d 1", r, np, npn, 1 - r); end
    end
    checks++; if (load_count !== 16'd1 || load_count_nd !== 16'd2 || skip_count_nd !== 16'd0) begin
      errors++; $display("FAIL t3_counts: lc=%0d lc_nd=%0d sc_nd=%0d expected 1 2 0", load_count, load_count_nd, skip_count_nd); end
    checks++; if (gain_value_nd !== 14'h0200 || grant_id_nd !== 2'd0 || busy_nd !== 1'b0 || req_ready_nd !== 4'hF) begin
      errors++; $display("FAIL t3_nd_state: val=%h id=%0d busy=%0b rdy=%b expected 0200 0 0 1111",
        gain_value_nd, grant_id_nd, busy_nd, req_ready_nd); end
  endtask

  task automatic test_no_overwrite();
    do_reset();
    set_gain(0, 14'h0100);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 3) begin set_gain(1, 14'h0111); req_valid = 4'b0010; end
      if (k == 4) set_gain(1, 14'h0222);
      if (k == 6) begin
        checks++; if (req_ready[1] !== 1'b0) begin
          errors++; $display("FAIL t4_full_hold: rdy1=%0b expected 0", req_ready[1]); end
      end
      if (k == 11) begin
        checks++; if (req_ready[1] !== 1'b1) begin
          errors++; $display("FAIL t4_ready_after_grant: rdy1=%0b expected 1", req_ready[1]); end
      end
      if (k == 12) begin
        checks++; if (gain_load !== 1'b1 || gain_value !== 14'h0111 || grant_id !== 2'd1 || req_ready[1] !== 1'b0) begin
          errors++; $display("FAIL t4_first_gain: load=%0b val=%h id=%0d rdy1=%0b expected 1 0111 1 0",
            gain_load, gain_value, grant_id, req_ready[1]); end
        req_valid = '0;
      end
      if (k == 22) begin
        checks++; if (gain_load !== 1'b1 || gain_value !== 14'h0222 || grant_id !== 2'd1) begin
          errors++; $display("FAIL t4_second_gain: load=%0b val=%h id=%0d expected 1 0222 1", gain_load, gain_value, grant_id); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int np;
    do_reset();
    set_gain(0, 14'h0300); set_gain(3, 14'h0303);
    req_valid = 4'b1001;
    tick();
    set_gain(0, 14'h0301);
    req_valid = 4'b0001;
    tick(); tick();
    req_valid = '0;
    checks++; if (gain_load !== 1'b1) begin
      errors++; $display("FAIL t5_pulse_before_reset: load=%0b expected 1", gain_load); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({gain_load, gain_value, busy, grant_id, load_count, skip_count, req_ready} !== '0) begin
      errors++; $display("FAIL t5_async_clear: load=%0b val=%h busy=%0b id=%0d lc=%0d rdy=%b expected all 0",
        gain_load, gain_value, busy, grant_id, load_count, req_ready); end
    tick(); tick();
    rst_n = 1'b1;
    np = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (gain_load) np++;
    end
    checks++; if (np != 0 || load_count !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_no_resume: pulses=%0d lc=%0d busy=%0b expected 0 0 0", np, load_count, busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_cnt;
    int w;
    do_reset();
    force dut.r_load_count = 16'hFE0C;
    tick();
    release dut.r_load_count;
    tick();
    exp_cnt = 16'hFE0C;
    checks++; if (load_count !== exp_cnt) begin
      errors++; $display("FAIL t6_preload: lc=%h expected %h", load_count, exp_cnt); end
    set_gain(0, 14'h0010); set_gain(1, 14'h0020);
    req_valid = 4'b0011;
    for (int n = 0; n < 1000; n++) begin
      w = 0;
      do begin tick(); w++; end while (!gain_load && w < 30);
      checks++;
      if (!gain_load) begin
        errors++; $display("FAIL t6_timeout: no gain_load for grant %0d", n);
        break;
      end
      exp_cnt = exp_cnt + 16'd1;
      if (grant_id !== 2'(n % 2) || load_count !== exp_cnt || gain_value !== ((n % 2 == 0) ? 14'h0010 : 14'h0020)) begin
        errors++; $display("FAIL t6_grant%0d: id=%0d lc=%h val=%h expected %0d %h %h", n, grant_id, load_count,
          gain_value, n % 2, exp_cnt, (n % 2 == 0) ? 14'h0010 : 14'h0020); end
    end
    req_valid = '0;
    checks++; if (load_count !== 16'h01F4 || skip_count !== 16'd0) begin
      errors++; $display("FAIL t6_wrap: lc=%h sc=%0d expected 01f4 0", load_count, skip_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip_dup();
    test_no_overwrite();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
